// File: rtl/ahb_apb_bridge_if.sv
// AHB-slave / APB-master signal bundle for the single-slave bridge.
// The slave modport is the bridge's view; master is the surrounding bus/testbench view.
interface ahb_apb_bridge_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        PCLK;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADYIN, PRDATA, PREADY,
    output HREADYOUT, HRDATA, HRESP, PCLK, PRESETn, PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADYIN, PRDATA, PREADY,
    input  HREADYOUT, HRDATA, HRESP, PCLK, PRESETn, PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// Single-slave AHB-to-APB bridge: one transfer at a time, AHB data phase is
// stretched via HREADYOUT until the APB ACCESS phase sees PREADY.
module ahb_apb_bridge (
  input  logic             HCLK,
  input  logic             HRESETn,   // active-high despite the name
  ahb_apb_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WDATA, SETUP, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        pwrite_q, pwrite_d;
  logic        accept;

  // Transfer size and the SEQ/NONSEQ distinction do not change the APB access.
  logic unused_ok;
  assign unused_ok = ^{bus.HSIZE, bus.HTRANS[0]};

  assign accept = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    pwrite_d = pwrite_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d  = bus.HADDR;
          pwrite_d = bus.HWRITE;
          state_d  = bus.HWRITE ? WDATA : SETUP;
        end
      end
      WDATA: begin
        // AHB data phase: write data is only valid during this cycle
        pwdata_d = bus.HWDATA;
        state_d  = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          state_d = IDLE;
          if (!pwrite_q) hrdata_d = bus.PRDATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready and APB strobes decode straight from state, so an async reset clears them at once.
  assign bus.HREADYOUT = (state_q == IDLE);
  assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.HRDATA    = hrdata_q;
  assign bus.HRESP     = 2'b00;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PCLK      = HCLK;
  assign bus.PRESETn   = HRESETn;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: driver pushes expected APB/AHB responses,
// an independent negedge monitor pops and compares them.
module tb_ahb_apb_bridge;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  ahb_apb_bridge_if bus();

  ahb_apb_bridge dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } apb_exp_t;
  typedef struct { logic [31:0] rdata; int lat; } ahb_exp_t;

  apb_exp_t    apb_q[$];
  ahb_exp_t    ahb_q[$];
  apb_exp_t    ae;
  ahb_exp_t    he;
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] last_rd = '0;
  int          apb_waits = 0;
  logic [31:0] apb_rdata = '0;
  int          lowcnt = 0;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // APB responder: holds PREADY low for apb_waits ACCESS cycles, junk PRDATA until ready.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn && bus.PSEL && bus.PENABLE) begin
        bus.PREADY = (acc_cnt >= apb_waits);
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        bus.PREADY = 1'($urandom_range(0, 1));
      end
      bus.PRDATA = bus.PREADY ? apb_rdata : $urandom;
    end
  end

  // Monitor / scoreboard
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      if (bus.PENABLE) chk("penable_without_psel", 32'(bus.PSEL), 32'd1);
      if (bus.PSEL && !bus.PENABLE) begin
        if (apb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_apb_setup: got PADDR %h expected no transfer", bus.PADDR);
        end else begin
          ae = apb_q.pop_front();
          chk("setup_paddr", bus.PADDR, ae.addr);
          chk("setup_pwrite", 32'(bus.PWRITE), 32'(ae.wr));
          if (ae.wr) chk("setup_pwdata", bus.PWDATA, ae.wdata);
        end
        acc_addr = bus.PADDR; acc_wdata = bus.PWDATA; acc_wr = bus.PWRITE;
      end
      if (bus.PSEL && bus.PENABLE) begin
        chk("access_paddr_stable", bus.PADDR, acc_addr);
        chk("access_pwrite_stable", 32'(bus.PWRITE), 32'(acc_wr));
        chk("access_pwdata_stable", bus.PWDATA, acc_wdata);
      end
      if (!bus.HREADYOUT) lowcnt++;
      else if (lowcnt > 0) begin
        if (ahb_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_completion: got %0d wait cycles expected no transfer", lowcnt);
        end else begin
          he = ahb_q.pop_front();
          chk("hreadyout_low_cycles", 32'(lowcnt), 32'(he.lat));
          chk("hrdata", bus.HRDATA, he.rdata);
          chk("hresp", 32'(bus.HRESP), 32'd0);
        end
        lowcnt = 0;
      end
    end else lowcnt = 0;
  end

  task automatic go_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HREADYIN = 1'b1;
  endtask

  // Called at a negedge with HREADYOUT=1; returns after the accept edge data phase is driven.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int waits, input logic [1:0] trans);
    bus.HSEL = 1'b1; bus.HREADYIN = 1'b1; bus.HTRANS = trans;
    bus.HADDR = addr; bus.HWRITE = wr; bus.HSIZE = 3'b010; bus.HWDATA = $urandom;
    apb_waits = waits; apb_rdata = rdata;
    apb_q.push_back('{addr: addr, wr: wr, wdata: wdata});
    if (!wr) last_rd = rdata;
    ahb_q.push_back('{rdata: last_rd, lat: (wr ? 3 : 2) + waits});
    @(posedge HCLK); #1;
    // Bridge is busy now: scramble address-phase inputs, present write data
    bus.HSEL = 1'($urandom); bus.HTRANS = 2'($urandom); bus.HADDR = $urandom;
    bus.HWRITE = 1'($urandom); bus.HWDATA = wdata;
    if (wr) begin
      @(posedge HCLK); #1;
      bus.HWDATA = $urandom;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!bus.HREADYOUT && n < 60);
    if (!bus.HREADYOUT) begin
      checks++; fails++;
      $display("FAIL completion_timeout: got HREADYOUT %0b expected 1 within 60 cycles", bus.HREADYOUT);
    end
    go_idle();
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits, input logic [1:0] trans);
    issue(wr, addr, wdata, rdata, waits, trans);
    wait_done();
  endtask

  task automatic idle_check(input string nm);
    repeat (2) begin
      @(negedge HCLK);
      chk({nm, "_psel"}, 32'(bus.PSEL), 32'd0);
      chk({nm, "_hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
    end
  endtask

  initial begin
    int n;
    go_idle();
    bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010; bus.HWDATA = '0;
    repeat (2) @(negedge HCLK);
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hrdata", bus.HRDATA, 32'd0);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_paddr", bus.PADDR, 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_pwdata", bus.PWDATA, 32'd0);
    chk("rst_presetn", 32'(bus.PRESETn), 32'd1);
    HRESETn = 1'b0;
    @(negedge HCLK);

    // Directed: single write, single read, wait-state read
    xfer(1'b1, 32'h10, 32'hA5A5A5A5, 32'h0, 0, 2'b10);
    xfer(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2'b10);
    xfer(1'b0, 32'h10, 32'h0, 32'h12345678, 3, 2'b10);

    // SEQ burst writes then reads
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'h14 + 32'(4 * i), 32'hA5A5A5A6 + 32'(i), 32'h0, 0, 2'b11);
    for (int i = 0; i < 4; i++)
      xfer(1'b0, 32'h24 + 32'(4 * i), 32'h0, 32'hDEADBEF0 + 32'(i), 0, 2'b11);

    // Ignored requests
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00; bus.HREADYIN = 1'b1; idle_check("ign_htrans_idle");
    bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HREADYIN = 1'b1; idle_check("ign_htrans_busy");
    bus.HSEL = 1'b0; bus.HTRANS = 2'b10; bus.HREADYIN = 1'b1; idle_check("ign_hsel0");
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HREADYIN = 1'b0; idle_check("ign_hreadyin0");
    go_idle();
    @(negedge HCLK);

    // Reset during a stalled ACCESS
    issue(1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 20, 2'b10);
    go_idle();
    n = 0;
    while (!bus.PENABLE && n < 20) begin @(negedge HCLK); n++; end
    chk("reached_access", 32'(bus.PENABLE), 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    chk("midrst_psel", 32'(bus.PSEL), 32'd0);
    chk("midrst_penable", 32'(bus.PENABLE), 32'd0);
    chk("midrst_hrdata", bus.HRDATA, 32'd0);
    chk("midrst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    apb_q.delete(); ahb_q.delete(); last_rd = '0;
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    xfer(1'b0, 32'h44, 32'h0, 32'h600DF00D, 1, 2'b10);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
           int'($urandom_range(0, 3)), $urandom_range(0, 1) ? 2'b11 : 2'b10);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge HCLK);
    end

    repeat (3) @(negedge HCLK);
    chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);
    chk("ahb_queue_drained", 32'(ahb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
